// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - pipelined multi-lane N-tap adder tree with valid/ready flow control
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (equals the pipeline advance enable)
//   op_flat    operands, lane c tap t at [(c*N_TAPS+t)*IN_W +: IN_W]
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   res_flat   results, lane c at [c*OUT_W +: OUT_W]
//   ovf        per-lane flag: shifted sum outside the OUT_W range, aligned with res_flat
module adder_tree_pipe #(
    parameter int N_TAPS   = 9,
    parameter int CHANNELS = 2,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int SIGNED   = 0,
    parameter int SHIFT    = 0,
    parameter int SAT      = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CHANNELS*N_TAPS*IN_W-1:0] op_flat,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CHANNELS*OUT_W-1:0]       res_flat,
    output logic [CHANNELS-1:0]             ovf
);

    localparam int LEVELS = (N_TAPS > 1) ? $clog2(N_TAPS) : 0;
    localparam int FW     = IN_W + LEVELS;
    // One extra bit so zero-extended unsigned sums stay non-negative when
    // the output stage treats everything as two's complement.
    localparam int EW     = FW + 1;
    localparam int CW     = (EW > OUT_W + 2) ? EW : OUT_W + 2;
    localparam int TL     = (LEVELS > 0) ? LEVELS : 1;
    localparam int HALF   = (N_TAPS + 1) / 2;
    localparam bit FITS   = (OUT_W >= FW - SHIFT);

    localparam logic signed [CW-1:0] MAXV =
        (CW'(1) <<< ((SIGNED != 0) ? OUT_W - 1 : OUT_W)) - CW'(1);
    localparam logic signed [CW-1:0] MINV =
        (SIGNED != 0) ? -(CW'(1) <<< (OUT_W - 1)) : '0;

    // Every node array carries one spare always-zero slot at index N_TAPS, so
    // the pairwise add can read 2*i+1 without a bounds test; slots past the
    // live node count of a level stay zero and never disturb the sum.
    logic [CHANNELS-1:0][N_TAPS:0][EW-1:0]          opx;
    logic [TL-1:0][CHANNELS-1:0][N_TAPS:0][EW-1:0]  tree;
    logic [TL-1:0]                                  vld;
    logic [CHANNELS-1:0][EW-1:0]                    full_sum;
    logic                                           last_vld;
    logic                                           advance;

    logic [CHANNELS-1:0][CW-1:0]                    s_w;
    logic [CHANNELS-1:0]                            hi;
    logic [CHANNELS-1:0]                            lo;
    logic [CHANNELS-1:0][OUT_W-1:0]                 res_n;
    logic [CHANNELS-1:0]                            ovf_n;

    // A stalled output register is the only hold point; bubbles anywhere
    // upstream are advanced together with the rest of the pipe.
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    always_comb begin
        opx = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int t = 0; t < N_TAPS; t++) begin
                if (SIGNED != 0)
                    opx[c][t] = EW'(signed'(op_flat[(c*N_TAPS+t)*IN_W +: IN_W]));
                else
                    opx[c][t] = EW'(op_flat[(c*N_TAPS+t)*IN_W +: IN_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld  <= '0;
            tree <= '0;
        end else if (advance) begin
            for (int l = 0; l < LEVELS; l++) begin
                vld[l] <= (l == 0) ? in_valid : vld[(l == 0) ? 0 : l - 1];
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int i = 0; i < HALF; i++) begin
                        if (l == 0)
                            tree[0][c][i] <= opx[c][2*i] + opx[c][2*i+1];
                        else
                            tree[l][c][i] <= tree[(l == 0) ? 0 : l - 1][c][2*i]
                                           + tree[(l == 0) ? 0 : l - 1][c][2*i+1];
                    end
                end
            end
        end
    end

    generate
        if (LEVELS == 0) begin : g_flat
            assign last_vld = in_valid;
            for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
                assign full_sum[c] = opx[c][0];
            end
        end else begin : g_tree
            assign last_vld = vld[LEVELS-1];
            for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
                assign full_sum[c] = tree[LEVELS-1][c][0];
            end
        end
    endgenerate

    // Output stage: normalise, then range-test against the OUT_W limits.
    always_comb begin
        s_w   = '0;
        hi    = '0;
        lo    = '0;
        res_n = '0;
        ovf_n = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            s_w[c] = CW'($signed(full_sum[c]) >>> SHIFT);
            hi[c]  = $signed(s_w[c]) > MAXV;
            lo[c]  = $signed(s_w[c]) < MINV;
            ovf_n[c] = !FITS && (hi[c] || lo[c]);
            if ((SAT != 0) && hi[c])
                res_n[c] = MAXV[OUT_W-1:0];
            else if ((SAT != 0) && lo[c])
                res_n[c] = MINV[OUT_W-1:0];
            else
                res_n[c] = s_w[c][OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            res_flat  <= '0;
            ovf       <= '0;
        end else if (advance) begin
            out_valid <= last_vld;
            if (last_vld) begin
                res_flat <= res_n;
                ovf      <= ovf_n;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb/tb_adder_tree_pipe.sv - self-checking bench for adder_tree_pipe
module tb_adder_tree_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [143:0] op;
    logic         v1;
    logic [15:0]  op1;

    logic         ir_m, ov_m, ir_w, ov_w, ir_g, ov_g, ir_h, ov_h, ir1, ov1;
    logic [15:0]  res_m, res_w, res_h, res1;
    logic [31:0]  res_g;
    logic [1:0]   ovf_m, ovf_w, ovf_g, ovf_h, ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_tree_pipe #(.N_TAPS(9), .CHANNELS(2), .IN_W(8), .OUT_W(8), .SIGNED(0), .SHIFT(0), .SAT(1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_m), .op_flat(op),
        .out_valid(ov_m), .out_ready(out_ready), .res_flat(res_m), .ovf(ovf_m));

    adder_tree_pipe #(.N_TAPS(9), .CHANNELS(2), .IN_W(8), .OUT_W(8), .SIGNED(0), .SHIFT(0), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w), .op_flat(op),
        .out_valid(ov_w), .out_ready(out_ready), .res_flat(res_w), .ovf(ovf_w));

    adder_tree_pipe #(.N_TAPS(9), .CHANNELS(2), .IN_W(8), .OUT_W(16), .SIGNED(1), .SHIFT(0), .SAT(1)) dut_g (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_g), .op_flat(op),
        .out_valid(ov_g), .out_ready(out_ready), .res_flat(res_g), .ovf(ovf_g));

    adder_tree_pipe #(.N_TAPS(9), .CHANNELS(2), .IN_W(8), .OUT_W(8), .SIGNED(0), .SHIFT(4), .SAT(1)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_h), .op_flat(op),
        .out_valid(ov_h), .out_ready(out_ready), .res_flat(res_h), .ovf(ovf_h));

    adder_tree_pipe #(.N_TAPS(1), .CHANNELS(2), .IN_W(8), .OUT_W(8), .SIGNED(0), .SHIFT(0), .SAT(1)) dut_1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .op_flat(op1),
        .out_valid(ov1), .out_ready(out_ready), .res_flat(res1), .ovf(ovf1));

    // Reference sums for every instance sharing the 9-tap handshake.
    function automatic void model(input logic [143:0] o, output logic [15:0] rs, output logic [1:0] os,
                                  output logic [15:0] rw, output logic [31:0] rg, output logic [15:0] rh);
        for (int c = 0; c < 2; c++) begin
            int su;
            int ss;
            logic [7:0] b;
            su = 0;
            ss = 0;
            for (int t = 0; t < 9; t++) begin
                b = o[(c*9+t)*8 +: 8];
                su += int'(b);
                ss += int'(signed'(b));
            end
            rs[c*8 +: 8]   = (su > 255) ? 8'd255 : 8'(su);
            os[c]          = (su > 255);
            rw[c*8 +: 8]   = 8'(su);
            rg[c*16 +: 16] = 16'(ss);
            rh[c*8 +: 8]   = 8'(su >> 4);
        end
    endfunction

    task automatic send_one(input logic [143:0] o, output int lat);
        @(negedge clk);
        op = o;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = '0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ov_m) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        v1 = 1'b0;
        op1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (ov_m !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", ov_m); end
        checks++; if (res_m !== 16'h0) begin errors++; $display("FAIL reset_res got %h expected 0000", res_m); end
        checks++; if (ovf_m !== 2'b00) begin errors++; $display("FAIL reset_ovf got %b expected 00", ovf_m); end
        checks++; if (ir_m !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", ir_m); end
        checks++; if (ov1 !== 1'b0 || res1 !== 16'h0) begin errors++; $display("FAIL reset_single got %b/%h expected 0/0000", ov1, res1); end
    endtask

    // Directed sums: saturate/wrap on 9x255, signed 9x-128, shift of 9x16, and the exact 255/256 edge.
    task automatic test_directed();
        logic [15:0] e_rs [3] = '{16'h90FF, 16'h2DFF, 16'hFFFF};
        logic [1:0]  e_os [3] = '{2'b01, 2'b01, 2'b10};
        logic [15:0] e_rw [3] = '{16'h90F7, 16'h2D80, 16'h00FF};
        logic [31:0] e_rg [3] = '{32'h0090FFF7, 32'h002DFB80, 32'h010000FF};
        logic [15:0] e_rh [3] = '{16'h098F, 16'h0248, 16'h100F};
        logic [143:0] o;
        int lat;
        for (int v = 0; v < 3; v++) begin
            o = '0;
            for (int t = 0; t < 9; t++) begin
                case (v)
                    0: begin o[t*8 +: 8] = 8'hFF; o[(9+t)*8 +: 8] = 8'h10; end
                    1: begin o[t*8 +: 8] = 8'h80; o[(9+t)*8 +: 8] = 8'(t + 1); end
                    default: begin
                        o[t*8 +: 8]     = (t == 8) ? 8'h1F : 8'h1C;
                        o[(9+t)*8 +: 8] = (t == 8) ? 8'h20 : 8'h1C;
                    end
                endcase
            end
            send_one(o, lat);
            checks++; if (lat != 5) begin errors++; $display("FAIL dir%0d_latency got %0d expected 5", v, lat); end
            checks++; if (res_m !== e_rs[v]) begin errors++; $display("FAIL dir%0d_sat_res got %h expected %h", v, res_m, e_rs[v]); end
            checks++; if (ovf_m !== e_os[v]) begin errors++; $display("FAIL dir%0d_sat_ovf got %b expected %b", v, ovf_m, e_os[v]); end
            checks++; if (res_w !== e_rw[v]) begin errors++; $display("FAIL dir%0d_wrap_res got %h expected %h", v, res_w, e_rw[v]); end
            checks++; if (ovf_w !== e_os[v]) begin errors++; $display("FAIL dir%0d_wrap_ovf got %b expected %b", v, ovf_w, e_os[v]); end
            checks++; if (res_g !== e_rg[v] || ovf_g !== 2'b00) begin errors++; $display("FAIL dir%0d_signed got %h/%b expected %h/00", v, res_g, ovf_g, e_rg[v]); end
            checks++; if (res_h !== e_rh[v] || ovf_h !== 2'b00) begin errors++; $display("FAIL dir%0d_shift got %h/%b expected %h/00", v, res_h, ovf_h, e_rh[v]); end
        end
    endtask

    task automatic test_single_tap();
        int lat;
        @(negedge clk);
        op1 = {8'd7, 8'd200};
        v1 = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b expected 1", ir1); end
        @(posedge clk);
        #1;
        v1 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ov1) begin lat = k; break; end
        end
        checks++; if (lat != 1) begin errors++; $display("FAIL single_latency got %0d expected 1", lat); end
        checks++; if (res1 !== 16'h07C8 || ovf1 !== 2'b00) begin errors++; $display("FAIL single_res got %h/%b expected 07c8/00", res1, ovf1); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int recv = 0;
        logic [15:0] hold = '0;
        for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 10 && cyc < 17);
            in_valid = (sent < 20);
            op = '0;
            op[7:0]   = 8'(sent);
            op[79:72] = 8'(sent + 100);
            #1;
            if (cyc == 10) begin
                hold = res_m;
                checks++; if (ir_m !== 1'b0 || ov_m !== 1'b1) begin errors++; $display("FAIL stall_in_ready got ready=%b valid=%b expected 0/1", ir_m, ov_m); end
            end
            if (cyc > 10 && cyc < 17) begin
                checks++; if (res_m !== hold || ov_m !== 1'b1) begin errors++; $display("FAIL stall_hold got %h/%b expected %h/1", res_m, ov_m, hold); end
            end
            if (cyc == 17) begin
                checks++; if (ir_m !== 1'b1) begin errors++; $display("FAIL stall_release got %b expected 1", ir_m); end
            end
            if (ov_m && out_ready) begin
                checks++;
                if (res_m !== {8'(recv + 100), 8'(recv)} || ovf_m !== 2'b00) begin
                    errors++;
                    $display("FAIL stream_beat%0d got %h/%b expected %h/00", recv, res_m, ovf_m, {8'(recv + 100), 8'(recv)});
                end
                recv++;
            end
            if (in_valid && ir_m) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (recv != 20) begin errors++; $display("FAIL stream_count got %0d expected 20", recv); end
    endtask

    task automatic test_random();
        logic [143:0] q[$];
        logic [143:0] o;
        logic [15:0] rs, rw, rh;
        logic [1:0]  os;
        logic [31:0] rg;
        int sent = 0;
        int recv = 0;
        for (int cyc = 0; cyc < 20000 && recv < 2000; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 2000) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            for (int t = 0; t < 18; t++)
                op[t*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63));
            #1;
            checks++;
            if ({ir_w, ir_g, ir_h, ov_w, ov_g, ov_h} !== {{3{ir_m}}, {3{ov_m}}}) begin
                errors++;
                if (errors < 20) $display("FAIL rand_handshake got %b expected %b", {ir_w, ir_g, ir_h, ov_w, ov_g, ov_h}, {{3{ir_m}}, {3{ov_m}}});
            end
            if (ov_m && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra got out_valid with empty queue expected none");
                end else begin
                    o = q.pop_front();
                    model(o, rs, os, rw, rg, rh);
                    if (res_m !== rs || ovf_m !== os) begin errors++; if (errors < 20) $display("FAIL rand_sat%0d got %h/%b expected %h/%b", recv, res_m, ovf_m, rs, os); end
                    checks++; if (res_w !== rw || ovf_w !== os) begin errors++; if (errors < 20) $display("FAIL rand_wrap%0d got %h/%b expected %h/%b", recv, res_w, ovf_w, rw, os); end
                    checks++; if (res_g !== rg || ovf_g !== 2'b00) begin errors++; if (errors < 20) $display("FAIL rand_signed%0d got %h/%b expected %h/00", recv, res_g, ovf_g, rg); end
                    checks++; if (res_h !== rh || ovf_h !== 2'b00) begin errors++; if (errors < 20) $display("FAIL rand_shift%0d got %h/%b expected %h/00", recv, res_h, ovf_h, rh); end
                end
                recv++;
            end
            if (in_valid && ir_m) begin
                q.push_back(op);
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (recv != 2000 || q.size() != 0) begin errors++; $display("FAIL rand_count got %0d left %0d expected 2000 left 0", recv, q.size()); end
    endtask

    task automatic test_reset_inflight();
        int lat;
        logic [143:0] o;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1;
            op = {18{8'(i + 1)}};
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (ov_m !== 1'b1) begin errors++; $display("FAIL inflight_pre got %b expected 1", ov_m); end
        rst = 1'b0;
        #1;
        checks++; if (ov_m !== 1'b0) begin errors++; $display("FAIL inflight_valid got %b expected 0", ov_m); end
        checks++; if (res_m !== 16'h0 || ovf_m !== 2'b00) begin errors++; $display("FAIL inflight_res got %h/%b expected 0000/00", res_m, ovf_m); end
        checks++; if (ir_m !== 1'b1) begin errors++; $display("FAIL inflight_ready got %b expected 1", ir_m); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        o = '0;
        for (int t = 0; t < 9; t++) begin
            o[t*8 +: 8] = 8'd1;
            o[(9+t)*8 +: 8] = 8'd2;
        end
        send_one(o, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL inflight_latency got %0d expected 5", lat); end
        checks++; if (res_m !== 16'h1209 || ovf_m !== 2'b00) begin errors++; $display("FAIL inflight_result got %h/%b expected 1209/00", res_m, ovf_m); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_single_tap();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
